// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the decoder/host memory arbiter: state encoding,
// default bus widths, requester identifiers and the round-robin pick.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_WR = 3'd1,
        ST_ISSUE_RD = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_ACK      = 3'd4
    } state_e;

    typedef enum logic {
        REQ_DEC  = 1'b0,
        REQ_HOST = 1'b1
    } req_id_e;

    // On a tie the requester that did not win last time gets the grant.
    function automatic req_id_e pick_grant(input logic d_req, input logic h_req,
                                           input req_id_e last);
        req_id_e win;
        if (d_req && h_req) begin
            win = (last == REQ_HOST) ? REQ_DEC : REQ_HOST;
        end else if (d_req) begin
            win = REQ_DEC;
        end else begin
            win = REQ_HOST;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_arbiter_sat_counter16.sv
// 16-bit enabled up-counter that sticks at all-ones instead of wrapping.
module sat_counter16
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates decoder writes and host reads onto a single-port memory,
// one transaction at a time, round-robin on simultaneous requests.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_req,
    input  logic [ADDR_W-1:0] dec_adr,
    input  logic [DATA_W-1:0] dec_data,
    output logic              dec_ack,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_adr,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_data,
    output logic              mem_start,
    output logic              mem_rwn,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
);

    state_e  state;
    req_id_e last_grant;
    req_id_e win;
    logic    wr_done;
    logic    rd_done;

    assign win = pick_grant(dec_req, host_req, last_grant);

    // The mem_adr/mem_data registers double as the latched request payload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last_grant <= REQ_HOST;
            dec_ack    <= 1'b0;
            host_ack   <= 1'b0;
            host_data  <= '0;
            mem_start  <= 1'b0;
            mem_rwn    <= 1'b1;
            mem_adr    <= '0;
            mem_data   <= '0;
            busy       <= 1'b0;
        end else begin
            dec_ack   <= 1'b0;
            host_ack  <= 1'b0;
            mem_start <= 1'b0;
            mem_rwn   <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (dec_req || host_req) begin
                        last_grant <= win;
                        busy       <= 1'b1;
                        mem_start  <= 1'b1;
                        if (win == REQ_DEC) begin
                            state    <= ST_ISSUE_WR;
                            mem_rwn  <= 1'b0;
                            mem_adr  <= dec_adr;
                            mem_data <= dec_data;
                        end else begin
                            state   <= ST_ISSUE_RD;
                            mem_adr <= host_adr;
                        end
                    end
                end
                ST_ISSUE_WR: begin
                    state   <= ST_ACK;
                    dec_ack <= 1'b1;
                end
                ST_ISSUE_RD: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state     <= ST_ACK;
                    host_data <= mem_rdata;
                    host_ack  <= 1'b1;
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Counts land at the end of ACK, so an aborted transaction never counts.
    assign wr_done = (state == ST_ACK) && (last_grant == REQ_DEC);
    assign rd_done = (state == ST_ACK) && (last_grant == REQ_HOST);

    sat_counter16 u_wr_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (wr_done),
        .count (wr_count)
    );

    sat_counter16 u_rd_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (rd_done),
        .count (rd_count)
    );

endmodule
